// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: word type, controller states, round constants
// and the combinational round functions.
package sha256_pkg;

    localparam int WORD_W = 32;
    localparam int ROUNDS = 64;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUND,
        ST_ADD
    } state_e;

    localparam word_t K [ROUNDS] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [8*WORD_W-1:0] H_INIT =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic word_t big_sigma0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t big_sigma1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t ch(input word_t e, input word_t f, input word_t g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic word_t maj(input word_t a, input word_t b, input word_t c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    // Word 0 (H0 / a) sits in the most significant 32 bits.
    function automatic word_t hash_word(input logic [8*WORD_W-1:0] h, input int i);
        return h[(7-i)*WORD_W +: WORD_W];
    endfunction

endpackage

// File: rtl/sha256_round_ctrl_if.sv
// Message-word handshake between the W-schedule generator (master) and the
// round controller (slave); round_idx tells the generator which word to offer.
interface sha256_round_ctrl_if;
    import sha256_pkg::*;

    word_t      w_in;
    logic       w_valid;
    logic       w_ready;
    logic [5:0] round_idx;

    modport master (
        output w_in,
        output w_valid,
        input  w_ready,
        input  round_idx
    );

    modport slave (
        input  w_in,
        input  w_valid,
        output w_ready,
        output round_idx
    );

endinterface

// File: rtl/sha256_k_rom.sv
// Combinational round-constant lookup, shared with the W-schedule generator.
module sha256_k_rom
    import sha256_pkg::*;
(
    input  logic [5:0] idx_i,
    output word_t      k_o
);

    assign k_o = K[idx_i];

endmodule

// File: rtl/sha256_round_ctrl.sv
// SHA-256 compression sequencer: one round per accepted schedule word, then a
// single ADD cycle folds the working variables into the chaining value.
module sha256_round_ctrl
    import sha256_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [8*WORD_W-1:0]   hash_in,
    sha256_round_ctrl_if.slave    w_bus,
    output logic                  busy,
    output logic                  done,
    output logic [8*WORD_W-1:0]   digest
);

    state_e              state_q;
    word_t               wv_q   [8];
    word_t               hreg_q [8];
    word_t               wv_d   [8];
    logic [8*WORD_W-1:0] digest_q;
    logic [8*WORD_W-1:0] digest_d;
    logic [5:0]          idx_q;
    logic                w_ready_q;
    logic                busy_q;
    logic                done_q;
    word_t               k_w;
    word_t               t1;
    word_t               t2;

    sha256_k_rom u_k_rom (
        .idx_i (idx_q),
        .k_o   (k_w)
    );

    // Round and final-add datapath are purely combinational off the registers.
    always_comb begin
        t1 = wv_q[7] + big_sigma1(wv_q[4]) + ch(wv_q[4], wv_q[5], wv_q[6])
           + k_w + w_bus.w_in;
        t2 = big_sigma0(wv_q[0]) + maj(wv_q[0], wv_q[1], wv_q[2]);
        wv_d[0] = t1 + t2;
        wv_d[1] = wv_q[0];
        wv_d[2] = wv_q[1];
        wv_d[3] = wv_q[2];
        wv_d[4] = wv_q[3] + t1;
        wv_d[5] = wv_q[4];
        wv_d[6] = wv_q[5];
        wv_d[7] = wv_q[6];
        digest_d = '0;
        for (int i = 0; i < 8; i++) begin
            digest_d[(7-i)*WORD_W +: WORD_W] = hreg_q[i] + wv_q[i];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            w_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            digest_q  <= '0;
            for (int i = 0; i < 8; i++) begin
                wv_q[i]   <= '0;
                hreg_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q   <= ST_ROUND;
                        idx_q     <= '0;
                        w_ready_q <= 1'b1;
                        busy_q    <= 1'b1;
                        for (int i = 0; i < 8; i++) begin
                            wv_q[i]   <= hash_word(hash_in, i);
                            hreg_q[i] <= hash_word(hash_in, i);
                        end
                    end
                end
                ST_ROUND: begin
                    // No word offered means a stall: nothing moves, index holds.
                    if (w_bus.w_valid) begin
                        wv_q <= wv_d;
                        if (idx_q == 6'(ROUNDS - 1)) begin
                            state_q   <= ST_ADD;
                            idx_q     <= '0;
                            w_ready_q <= 1'b0;
                        end else begin
                            idx_q <= idx_q + 6'd1;
                        end
                    end
                end
                ST_ADD: begin
                    digest_q <= digest_d;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign w_bus.w_ready   = w_ready_q;
    assign w_bus.round_idx = idx_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign digest          = digest_q;

endmodule
